// File: rtl/frame_reader_if.sv
// Byte stream from the frame reader to the host link bridge.
interface frame_reader_if;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/frame_reader.sv
// Reads a captured frame back from SRAM port 1 and streams it out LSB-first as bytes.
// state | meaning
// IDLE  | waiting for start
// WAIT  | frame accepted, waiting for fetch_done
// READ  | issuing reads at addresses 0..last_addr
// DRAIN | all reads issued, emptying FIFO and serializer
// DONE  | one-cycle done pulse, then back to IDLE
module frame_reader #(
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  fetch_done,
  input  logic [17:0]           last_addr,
  output logic                  s1_RE,
  output logic [17:0]           s1_Addr,
  input  logic [31:0]           s1_RD,
  frame_reader_if.master        stream,
  output logic                  busy,
  output logic                  done
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW:0]   FULL_CNT = FIFO_DEPTH[PW:0];
  localparam logic [OW-1:0] OCC_MAX  = FIFO_DEPTH[OW-1:0];

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_READ, S_DRAIN, S_DONE} state_t;

  state_t            state;
  logic [18:0]       n_words;
  logic [18:0]       rd_cnt;
  logic [20:0]       pres_cnt;
  logic [RD_LAT-1:0] iss_pipe;
  logic [31:0]       fifo_mem [FIFO_DEPTH];
  logic [PW:0]       wr_ptr;
  logic [PW:0]       rd_ptr;
  logic [OW-1:0]     occ;
  logic [31:0]       word_q;
  logic [1:0]        sel;
  logic              word_ok;

  logic              issue;
  logic              cap;
  logic              xfer;
  logic              slot_free;
  logic              fifo_empty;
  logic              fifo_full;
  logic              pop;
  logic [31:0]       fifo_head;
  logic [7:0]        next_byte;
  logic [20:0]       last_idx;

  // occ counts words issued but not yet popped, so FIFO space is reserved at issue time
  always_comb begin
    issue      = (state == S_READ) && (rd_cnt != n_words) && (occ < OCC_MAX);
    cap        = iss_pipe[RD_LAT-1];
    fifo_empty = (wr_ptr == rd_ptr);
    fifo_full  = ((wr_ptr - rd_ptr) == FULL_CNT);
    fifo_head  = fifo_mem[rd_ptr[PW-1:0]];
    xfer       = stream.out_valid && stream.out_ready;
    slot_free  = !stream.out_valid || xfer;
    pop        = slot_free && !word_ok && !fifo_empty;
    next_byte  = word_ok ? word_q[{sel, 3'b000} +: 8] : fifo_head[7:0];
    last_idx   = {n_words, 2'b00} - 21'd1;
  end

  always_ff @(posedge clk) begin
    if (cap) fifo_mem[wr_ptr[PW-1:0]] <= s1_RD;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      n_words          <= '0;
      rd_cnt           <= '0;
      pres_cnt         <= '0;
      iss_pipe         <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      occ              <= '0;
      word_q           <= '0;
      sel              <= '0;
      word_ok          <= 1'b0;
      s1_RE            <= 1'b1;
      s1_Addr          <= '0;
      stream.out_valid <= 1'b0;
      stream.out_data  <= '0;
      stream.out_last  <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      assert (!(cap && fifo_full));

      if (issue) begin
        s1_RE   <= 1'b0;
        s1_Addr <= rd_cnt[17:0];
        rd_cnt  <= rd_cnt + 19'd1;
      end else begin
        s1_RE   <= 1'b1;
      end
      iss_pipe <= RD_LAT'({iss_pipe, ~s1_RE});
      if (cap) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      occ <= occ + OW'(issue) - OW'(pop);

      if (slot_free) begin
        if (word_ok || !fifo_empty) begin
          stream.out_valid <= 1'b1;
          stream.out_data  <= next_byte;
          stream.out_last  <= (pres_cnt == last_idx);
          pres_cnt         <= pres_cnt + 21'd1;
          if (word_ok) begin
            sel     <= sel + 2'd1;
            word_ok <= (sel != 2'd3);
          end else begin
            word_q  <= fifo_head;
            sel     <= 2'd1;
            word_ok <= 1'b1;
          end
        end else begin
          stream.out_valid <= 1'b0;
          stream.out_last  <= 1'b0;
        end
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            n_words  <= {1'b0, last_addr} + 19'd1;
            rd_cnt   <= '0;
            pres_cnt <= '0;
            busy     <= 1'b1;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (fetch_done) state <= S_READ;
        end
        S_READ: begin
          if (issue && (rd_cnt == n_words - 19'd1)) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (xfer && stream.out_last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_reader.sv
// Directed bench for frame_reader; three copies run side by side with RD_LAT = 2, 1, 4.
module tb_frame_reader;

  localparam int N_DUT = 3;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        fetch_done;
  logic        out_ready;
  logic        new_frame;
  logic [17:0] last_addr;
  int          exp_words;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          n_wait;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [17:0] a);
    logic [3:0] k;
    k = a[3:0];
    return {k, 4'h3, k, 4'h2, k, 4'h1, k, 4'h0};
  endfunction

  function automatic logic [7:0] exp_byte(input int b);
    return {4'((b / 4) % 16), 4'(b % 4)};
  endfunction

  for (genvar g = 0; g < N_DUT; g++) begin : gen_lat
    localparam int LAT = (g == 0) ? 2 : (g == 1) ? 1 : 4;

    logic        s1_re;
    logic [17:0] s1_addr;
    logic [31:0] s1_rd;
    logic        busy;
    logic        done;
    logic [31:0] sram_pipe [LAT];

    frame_reader_if u_if ();
    assign u_if.out_ready = out_ready;

    frame_reader #(.RD_LAT(LAT), .FIFO_DEPTH(DEPTH)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .fetch_done (fetch_done),
      .last_addr  (last_addr),
      .s1_RE      (s1_re),
      .s1_Addr    (s1_addr),
      .s1_RD      (s1_rd),
      .stream     (u_if),
      .busy       (busy),
      .done       (done)
    );

    // SRAM: data appears LAT cycles after the cycle s1_RE is low, garbage otherwise
    always @(posedge clk) begin
      sram_pipe[0] <= s1_re ? 32'hDEAD_BEEF : word_of(s1_addr);
      for (int i = 1; i < LAT; i++) sram_pipe[i] <= sram_pipe[i-1];
    end
    assign s1_rd = sram_pipe[LAT-1];

    int         rx = 0, iss = 0, pres = 0, started = 0, dn = 0, gaps = 0, t_re = -1, nw = 1;
    logic       prev_v = 1'b0, prev_x = 1'b0, prev_l = 1'b0, prev_lx = 1'b0;
    logic [7:0] prev_d = '0;
    logic       xfer;

    always @(negedge clk) begin
      if (reset) begin
        rx = 0; iss = 0; pres = 0; started = 0;
        prev_v = 1'b0; prev_x = 1'b0; prev_lx = 1'b0;
      end else begin
        if (new_frame) begin
          rx = 0; iss = 0; pres = 0; started = 0; dn = 0; gaps = 0; t_re = -1;
          nw = exp_words;
        end
        if (!s1_re) begin
          check("rd_addr", 32'(s1_addr), 32'(iss));
          check("rd_in_range", 32'(iss < nw), 32'd1);
          if (iss == 0) t_re = cyc;
          iss++;
        end
        if (u_if.out_valid && (!prev_v || prev_x)) begin
          if (pres == 0) check("first_byte_latency", 32'((cyc - t_re) <= LAT + 2), 32'd1);
          if (pres % 4 == 0) started++;
          pres++;
        end
        if (busy) check("occupancy", 32'((iss - started) <= DEPTH), 32'd1);
        if (prev_v && !prev_x) begin
          check("hold_valid", 32'(u_if.out_valid), 32'd1);
          check("hold_data", 32'(u_if.out_data), 32'(prev_d));
          check("hold_last", 32'(u_if.out_last), 32'(prev_l));
        end
        xfer = u_if.out_valid && out_ready;
        if (rx > 0 && rx < 4 * nw && !u_if.out_valid) gaps++;
        if (xfer) begin
          check("byte", 32'(u_if.out_data), 32'(exp_byte(rx)));
          check("last", 32'(u_if.out_last), 32'(rx == 4 * nw - 1));
          rx++;
        end
        if (prev_lx) check("done_pulse", 32'(done), 32'd1);
        if (done) begin
          dn++;
          check("done_timing", 32'(prev_lx), 32'd1);
          check("busy_at_done", 32'(busy), 32'd0);
        end
        prev_lx = xfer && u_if.out_last;
        prev_v  = u_if.out_valid;
        prev_x  = xfer;
        prev_d  = u_if.out_data;
        prev_l  = u_if.out_last;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [17:0] la);
    tick();
    last_addr = la;
    exp_words = int'(la) + 1;
    start     = 1'b1;
    new_frame = 1'b1;
    tick();
    start     = 1'b0;
    new_frame = 1'b0;
    last_addr = ~la;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_re"},    32'(gen_lat[0].s1_re), 32'd1);
    check({tag, "_addr"},  32'(gen_lat[0].s1_addr), 32'd0);
    check({tag, "_valid"}, 32'(gen_lat[0].u_if.out_valid), 32'd0);
    check({tag, "_data"},  32'(gen_lat[0].u_if.out_data), 32'd0);
    check({tag, "_last"},  32'(gen_lat[0].u_if.out_last), 32'd0);
    check({tag, "_busy"},  32'(gen_lat[0].busy), 32'd0);
    check({tag, "_done"},  32'(gen_lat[0].done), 32'd0);
  endtask

  task automatic wait_idle(input int budget, input bit rnd, input bit no_gaps);
    int n = 0;
    do begin
      tick();
      if (rnd) out_ready = ($urandom_range(0, 9) < 3);
      n++;
    end while ((gen_lat[0].busy || gen_lat[1].busy || gen_lat[2].busy) && n < budget);
    out_ready = 1'b1;
    check("frame_timeout", 32'(n < budget), 32'd1);
    tick();
    tick();
    check("bytes_lat2", 32'(gen_lat[0].rx), 32'(4 * exp_words));
    check("bytes_lat1", 32'(gen_lat[1].rx), 32'(4 * exp_words));
    check("bytes_lat4", 32'(gen_lat[2].rx), 32'(4 * exp_words));
    check("done_cnt_lat2", 32'(gen_lat[0].dn), 32'd1);
    check("done_cnt_lat1", 32'(gen_lat[1].dn), 32'd1);
    check("done_cnt_lat4", 32'(gen_lat[2].dn), 32'd1);
    if (no_gaps) begin
      check("gaps_lat2", 32'(gen_lat[0].gaps), 32'd0);
      check("gaps_lat1", 32'(gen_lat[1].gaps), 32'd0);
      check("gaps_lat4", 32'(gen_lat[2].gaps), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; fetch_done = 1'b0; last_addr = '0;
    out_ready = 1'b1; new_frame = 1'b0; exp_words = 1;
    repeat (3) tick();
    @(negedge clk);
    check_reset_outputs("reset");
    tick();
    reset = 1'b0;

    // 4 words, sink always ready
    fetch_done = 1'b1;
    start_frame(18'd3);
    wait_idle(200, 1'b0, 1'b1);
    check("t1_busy_after", 32'(gen_lat[0].busy), 32'd0);

    // single word
    start_frame(18'd0);
    wait_idle(200, 1'b0, 1'b1);
    check("t2_reads_lat2", 32'(gen_lat[0].iss), 32'd1);
    check("t2_reads_lat4", 32'(gen_lat[2].iss), 32'd1);

    // start before the frame is complete; fetch_done drops once reading
    fetch_done = 1'b0;
    start_frame(18'd7);
    repeat (50) @(negedge clk);
    check("t3_no_reads_lat2", 32'(gen_lat[0].iss), 32'd0);
    check("t3_no_reads_lat1", 32'(gen_lat[1].iss), 32'd0);
    check("t3_no_reads_lat4", 32'(gen_lat[2].iss), 32'd0);
    check("t3_busy_wait", 32'(gen_lat[0].busy), 32'd1);
    tick();
    fetch_done = 1'b1;
    n_wait = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!gen_lat[0].s1_re) break;
      n_wait++;
    end
    check("t3_read_delay", 32'(n_wait <= 2), 32'd1);
    tick();
    fetch_done = 1'b0;
    wait_idle(300, 1'b0, 1'b1);
    fetch_done = 1'b1;

    // 64 words with a long stall and then a sparse random sink
    start_frame(18'd63);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (gen_lat[0].rx >= 20) break;
    end
    check("t4_reach", 32'(gen_lat[0].rx >= 20), 32'd1);
    tick();
    out_ready = 1'b0;
    repeat (60) tick();
    check("t4_stall_busy_lat2", 32'(gen_lat[0].busy), 32'd1);
    check("t4_stall_busy_lat1", 32'(gen_lat[1].busy), 32'd1);
    check("t4_stall_busy_lat4", 32'(gen_lat[2].busy), 32'd1);
    wait_idle(6000, 1'b1, 1'b0);

    // start pulses while busy are ignored
    start_frame(18'd7);
    repeat (3) begin
      tick();
      tick();
      last_addr = 18'd20;
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    wait_idle(300, 1'b0, 1'b1);
    check("t5_reads", 32'(gen_lat[0].iss), 32'd8);

    // reset mid-frame, then a fresh frame
    start_frame(18'd15);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (gen_lat[0].rx >= 10) break;
    end
    check("t6_reach", 32'(gen_lat[0].rx >= 10), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    check_reset_outputs("midreset");
    tick();
    reset = 1'b0;
    start_frame(18'd2);
    wait_idle(200, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_reader.md
Name: frame_reader

Overview:
- Downstream consumer of the camera capture stage. After a frame has been written into the frame SRAM, it reads the frame back through the SRAM's second port.
- Each 32-bit word is unpacked into bytes and streamed over a valid/ready byte interface to the host link (UART/SPI bridge).
- Words are read from address 0 up to and including the capture stage's last written address.
- It is the only agent that reads frame memory after capture.

Parameters:
- RD_LAT, 2, SRAM read latency in clk cycles, from s1_RE low to s1_RD valid; legal range 1..4.
- FIFO_DEPTH, 4, word prefetch FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; request readout of the captured frame.
- fetch_done  in  1  level from the capture stage; high once the frame is complete in SRAM.
- last_addr  in  18  highest word address written by the capture stage.
- s1_RE  out  1  SRAM read enable, active low.
- s1_Addr  out  18  SRAM read address.
- s1_RD  in  32  SRAM read data, valid RD_LAT cycles after a read is issued.
- out_valid  out  1  byte available on out_data.
- out_ready  in  1  sink accepts the byte; a transfer occurs when out_valid & out_ready.
- out_data  out  8  byte payload.
- out_last  out  1  high with the final byte of the frame.
- busy  out  1  high from start acceptance until the final byte is transferred.
- done  out  1  one-cycle pulse, asserted the cycle after the final byte transfer.

Behaviour:
- Reset:
  - s1_RE=1, s1_Addr=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0.
  - FIFO is emptied and in-flight reads are discarded.
  - State returns to IDLE.
  - Reset applies from any state, including mid-frame.
- State machine:
  - IDLE: a start pulse latches n_words=last_addr+1 (19-bit), sets busy=1, and moves to WAIT. start is ignored in every other state.
  - WAIT: if fetch_done=1, go to READ; this includes the case where fetch_done is already high on the cycle start is accepted. Otherwise hold.
  - READ: issue reads at addresses 0..last_addr. Go to DRAIN one cycle after the read of address last_addr is issued.
  - DRAIN: no further reads. Wait until every byte has been transferred, then go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, then go to IDLE.
- last_addr is sampled only at start acceptance; later changes are ignored.
- Read issue rules:
  - A read is issued in a cycle (s1_RE=0, s1_Addr=address) only if FIFO occupancy + reads in flight < FIFO_DEPTH.
  - Reads are otherwise back-to-back, one per cycle.
  - s1_RE=1 whenever no read is issued; s1_Addr holds its last value.
  - Returned data is captured into the FIFO exactly RD_LAT cycles after issue, using a shift register of issue flags.
  - The FIFO can never overflow. Overflow is an assertion failure.
- Serializer:
  - Pops one word per 4 bytes and emits bytes LSB first: [7:0], [15:8], [23:16], [31:24]. This matches the capture packing of the first pixel byte into [7:0].
  - out_data and out_valid are registered.
  - While out_valid=1 and out_ready=0, out_data and out_last hold stable.
  - The next byte may be presented in the cycle after a transfer, giving 1 byte/cycle sustained throughput.
  - First byte latency: out_valid rises no later than RD_LAT+3 cycles after entering READ.
- Counters:
  - Word issue counter is 19-bit, so a full range of 2^18 words is handled with no wrap.
  - Byte counter counts to 4*n_words.
  - out_last=1 only on byte 4*n_words-1.
- Boundary cases:
  - last_addr=0: exactly 4 bytes are sent.
  - last_addr=3FFFF: 2^20 bytes are sent and s1_Addr ends at 3FFFF.
  - fetch_done falling after READ has been entered is ignored.
  - out_ready may be held low indefinitely. All state holds and there is no data loss.

Test Plan:
- fetch_done=1, last_addr=3, SRAM word k=0x(k)3(k)2(k)1(k)0 pattern, out_ready=1, start pulse -> 16 bytes 00,01,02,03,10,...,33 on consecutive cycles; out_last only with byte 0x33; done pulses once the next cycle; busy low after.
- last_addr=0, start -> exactly one read at address 0, 4 bytes, out_last on the 4th byte.
- start with fetch_done=0, raise fetch_done 50 cycles later -> s1_RE stays 1 throughout WAIT; reads begin within 2 cycles of fetch_done.
- last_addr=63, random out_ready (30% high) -> all 256 bytes in order; a checker confirms occupancy+in-flight ≤ FIFO_DEPTH every cycle; out_data is stable while stalled; repeat with RD_LAT=1 and RD_LAT=4.
- start pulses during busy -> ignored; no restart and byte count is unchanged.
- reset asserted after 10 bytes, then a fresh start -> all outputs take reset values the next cycle; the new frame restarts at address 0 and byte 0x00.
